// File: rtl/pipe_stage_chain_if.sv
// Handshake and payload bundle between the pipeline register chain and the stage logic around it.
interface pipe_stage_chain_if #(
    parameter int STAGES = 4,
    parameter int WIDTH  = 64
);
    logic                          in_valid;
    logic                          in_ready;
    logic                          out_ready;
    logic                          out_valid;
    logic [STAGES-1:0][WIDTH-1:0]  stg_data;
    logic [STAGES-1:0][WIDTH-1:0]  q_data;
    logic [STAGES-1:0]             stg_hold;
    logic [STAGES-1:0]             flush_mask;
    logic [STAGES-1:0]             q_valid;
    logic [STAGES-1:0]             stg_go;

    modport master (
        output in_valid, stg_data, stg_hold, flush_mask, out_ready,
        input  in_ready, out_valid, q_valid, q_data, stg_go
    );

    modport slave (
        input  in_valid, stg_data, stg_hold, flush_mask, out_ready,
        output in_ready, out_valid, q_valid, q_data, stg_go
    );
endinterface

// File: rtl/pipe_stage_chain.sv
// Parametrised chain of valid+payload pipeline registers with per-stage hold, bubble
// collapsing, per-register flush and saturating stall/flush counters.
module pipe_stage_reg #(
    parameter int WIDTH = 64
) (
    input  logic             core_clk,
    input  logic             core_rst_n,
    input  logic             acc,
    input  logic             ld_vld,
    input  logic             flush,
    input  logic [WIDTH-1:0] ld_data,
    output logic             v,
    output logic [WIDTH-1:0] data
);
    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            v    <= 1'b0;
            data <= '0;
        end else begin
            // flush overrides both load and hold of the valid bit
            if (flush)    v <= 1'b0;
            else if (acc) v <= ld_vld;
            if (acc && ld_vld) data <= ld_data;
        end
    end
endmodule

module pipe_stage_chain #(
    parameter int STAGES = 4,
    parameter int WIDTH  = 64,
    parameter int CNT_W  = 32
) (
    input  logic                           core_clk,
    input  logic                           core_rst_n,
    pipe_stage_chain_if.slave              bus,
    output logic [$clog2(STAGES+1)-1:0]    occupancy,
    output logic                           empty,
    output logic [CNT_W-1:0]               stall_cnt,
    output logic [CNT_W-1:0]               flush_cnt
);
    localparam int OCC_W = $clog2(STAGES+1);

    logic [STAGES:0]              acc;
    logic [STAGES-1:0]            go;
    logic [STAGES-1:0]            ld_vld;
    logic [STAGES-1:0]            q_v;
    logic [STAGES-1:0][WIDTH-1:0] q_d;
    logic                         stall_hit;
    logic                         flush_hit;

    // Accept ripples from the retire sink back to reg 0; an empty reg always accepts.
    always_comb begin
        acc         = '0;
        go          = '0;
        acc[STAGES] = bus.out_ready;
        for (int k = STAGES-1; k >= 0; k--) begin
            go[k]  = q_v[k] & ~bus.stg_hold[k] & acc[k+1];
            acc[k] = ~q_v[k] | go[k];
        end
    end

    assign ld_vld = {go[STAGES-2:0], bus.in_valid};

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        pipe_stage_reg #(.WIDTH(WIDTH)) u_stg (
            .core_clk   (core_clk),
            .core_rst_n (core_rst_n),
            .acc        (acc[k]),
            .ld_vld     (ld_vld[k]),
            .flush      (bus.flush_mask[k]),
            .ld_data    (bus.stg_data[k]),
            .v          (q_v[k]),
            .data       (q_d[k])
        );
    end

    assign bus.q_valid   = q_v;
    assign bus.q_data    = q_d;
    assign bus.stg_go    = go;
    assign bus.in_ready  = acc[0];
    assign bus.out_valid = q_v[STAGES-1] & ~bus.stg_hold[STAGES-1];
    assign empty         = ~|q_v;

    always_comb begin
        occupancy = '0;
        for (int k = 0; k < STAGES; k++)
            occupancy = occupancy + OCC_W'(q_v[k]);
    end

    assign stall_hit = |(bus.stg_hold & q_v);
    assign flush_hit = |(bus.flush_mask & q_v);

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_hit && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
            if (flush_hit && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
        end
    end
endmodule
